// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked single-port RAM.
// Holds the init-clear FSM encoding and the bank-index width helper.
package ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } ram_state_t;

   // Zero for a single bank, so callers must guard zero-width slices.
   function automatic int bank_idx_width(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 0;
   endfunction

endpackage

// File: rtl/ram_sp_bank.sv
// One bank: single-port word array with per-byte write mask and registered read.
// q holds its last read value while the bank is idle or writing.
module ram_sp_bank #(
   parameter int RowWidth  = 10,
   parameter int DataWidth = 32
) (
   input  logic                   clk,
   input  logic                   en,
   input  logic                   we,
   input  logic [RowWidth-1:0]    row,
   input  logic [DataWidth-1:0]   d,
   input  logic [DataWidth/8-1:0] wmask,
   output logic [DataWidth-1:0]   q
);

   localparam int Depth    = 2**RowWidth;
   localparam int NumBytes = DataWidth/8;

   logic [DataWidth-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < NumBytes; i++) begin
               if (wmask[i]) begin
                  mem[row][i*8 +: 8] <= d[i*8 +: 8];
               end
            end
         end else begin
            q <= mem[row];
         end
      end
   end

endmodule

// File: rtl/ram_sp_banked.sv
// Banked single-port RAM, low-order interleaved, optional output register.
// Define RAM_SP_INIT_CLEAR_EN to zero all rows after reset before accepting accesses.
//
// state    | meaning
// ST_CLEAR | writing zero to row clr_row of every bank, ready=0
// ST_READY | normal operation, accesses accepted
module ram_sp_banked
   import ram_pkg::*;
#(
   parameter int AddrWidth = 12,
   parameter int DataWidth = 32,
   parameter int NumBanks  = 4,
   parameter int Pipelined = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cen,
   input  logic                   rdwen,
   input  logic [AddrWidth-1:0]   a,
   input  logic [DataWidth-1:0]   d,
   input  logic [DataWidth/8-1:0] wmask,
   output logic [DataWidth-1:0]   q,
   output logic                   q_valid,
   output logic                   ready
);

   localparam int BankBits = bank_idx_width(NumBanks);
   localparam int RowBits  = (AddrWidth - BankBits > 0) ? (AddrWidth - BankBits) : 1;
   localparam int SelBits  = (BankBits > 0) ? BankBits : 1;
   localparam int Rows     = 2**(AddrWidth - BankBits);
   localparam int NumBytes = DataWidth/8;

   logic [SelBits-1:0]   bank_sel;
   logic [RowBits-1:0]   row_sel;
   logic                 accept;
   logic                 clearing;
   logic                 ready_i;
   logic [RowBits-1:0]   clr_row;

   assign bank_sel = SelBits'(a & AddrWidth'(NumBanks - 1));
   assign row_sel  = RowBits'(a >> BankBits);
   assign accept   = !cen && ready_i;
   assign ready    = ready_i;

`ifdef RAM_SP_INIT_CLEAR_EN
   ram_state_t         state, state_nxt;
   logic [RowBits-1:0] clr_row_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_row <= '0;
      end else begin
         state   <= state_nxt;
         clr_row <= clr_row_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_row_nxt = clr_row;
      clearing    = 1'b0;
      ready_i     = 1'b0;
      case (state)
         ST_CLEAR: begin
            clearing = 1'b1;
            if (clr_row == RowBits'(Rows - 1)) begin
               state_nxt = ST_READY;
            end else begin
               clr_row_nxt = clr_row + 1'b1;
            end
         end
         ST_READY: ready_i = 1'b1;
         default:  state_nxt = ST_CLEAR;
      endcase
   end
`else
   assign clearing = 1'b0;
   assign ready_i  = 1'b1;
   assign clr_row  = '0;
`endif

   logic                 bank_we;
   logic [RowBits-1:0]   bank_row;
   logic [DataWidth-1:0] bank_d;
   logic [NumBytes-1:0]  bank_wmask;
   logic [DataWidth-1:0] bank_q [NumBanks];

   // Clearing broadcasts a full-mask zero write to the same row of every bank.
   assign bank_we    = clearing || !rdwen;
   assign bank_row   = clearing ? clr_row : row_sel;
   assign bank_d     = clearing ? '0 : d;
   assign bank_wmask = clearing ? '1 : wmask;

   for (genvar i = 0; i < NumBanks; i++) begin : g_bank
      logic en_i;
      assign en_i = clearing || (accept && (bank_sel == SelBits'(i)));

      ram_sp_bank #(
         .RowWidth  (RowBits),
         .DataWidth (DataWidth)
      ) u_bank (
         .clk   (clk),
         .en    (en_i),
         .we    (bank_we),
         .row   (bank_row),
         .d     (bank_d),
         .wmask (bank_wmask),
         .q     (bank_q[i])
      );
   end

   logic               rd_v1;
   logic [SelBits-1:0] rd_bank;
   logic [DataWidth-1:0] rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_v1   <= 1'b0;
         rd_bank <= '0;
      end else begin
         rd_v1 <= accept && rdwen;
         if (accept && rdwen) begin
            rd_bank <= bank_sel;
         end
      end
   end

   assign rd_data = bank_q[rd_bank];

   if (Pipelined != 0) begin : g_pipe
      logic [DataWidth-1:0] q_r;
      logic                 qv_r;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q_r  <= '0;
            qv_r <= 1'b0;
         end else begin
            qv_r <= rd_v1;
            if (rd_v1) begin
               q_r <= rd_data;
            end
         end
      end

      assign q       = q_r;
      assign q_valid = qv_r;
   end else begin : g_direct
      // Bank outputs are shared by later reads of other banks, so keep a copy.
      logic [DataWidth-1:0] q_hold;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            q_hold <= '0;
         end else if (rd_v1) begin
            q_hold <= rd_data;
         end
      end

      assign q       = rd_v1 ? rd_data : q_hold;
      assign q_valid = rd_v1;
   end

endmodule

// File: tb/tb_ram_sp_banked.sv
// Bench for ram_sp_banked: Pipelined=0 and Pipelined=1 instances share stimulus.
// Array-based reference model with per-instance read latency and hold values.
module tb_ram_sp_banked;

   logic        clk = 1'b0;
   logic        rst;
   logic        cen;
   logic        rdwen;
   logic [5:0]  a;
   logic [31:0] d;
   logic [3:0]  wmask;
   logic [31:0] q0, q1;
   logic        qv0, qv1, ready0, ready1;

   always #5 clk = ~clk;

   ram_sp_banked #(.AddrWidth(6), .DataWidth(32), .NumBanks(4), .Pipelined(0)) u_p0 (
      .clk(clk), .rst(rst), .cen(cen), .rdwen(rdwen), .a(a), .d(d), .wmask(wmask),
      .q(q0), .q_valid(qv0), .ready(ready0));

   ram_sp_banked #(.AddrWidth(6), .DataWidth(32), .NumBanks(4), .Pipelined(1)) u_p1 (
      .clk(clk), .rst(rst), .cen(cen), .rdwen(rdwen), .a(a), .d(d), .wmask(wmask),
      .q(q1), .q_valid(qv1), .ready(ready1));

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [64];
   logic        s1_v;
   logic [31:0] s1_d, hold0, hold1;
   logic [31:0] rd_log [$];
   logic        logging = 1'b0;

   typedef struct {
      logic        c;
      logic        r;
      logic [5:0]  ad;
      logic [31:0] dd;
      logic [3:0]  wm;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      s1_v  = 1'b0;
      s1_d  = '0;
      hold0 = '0;
      hold1 = '0;
   endtask

   // One access cycle: drive, let the edge happen, advance the model, compare.
   task automatic step(input logic c, input logic r, input logic [5:0] ad,
                       input logic [31:0] dd, input logic [3:0] wm);
      logic        n_v;
      logic [31:0] n_d;
      logic        p1_v;
      logic [31:0] p1_d;
      cen = c; rdwen = r; a = ad; d = dd; wmask = wm;
      @(posedge clk);
      n_v = !c && r;
      n_d = mem_m[ad];
      if (!c && !r) begin
         for (int b = 0; b < 4; b++) begin
            if (wm[b]) mem_m[ad][b*8 +: 8] = dd[b*8 +: 8];
         end
      end
      p1_v = s1_v;
      p1_d = s1_d;
      s1_v = n_v;
      s1_d = n_d;
      if (n_v)  hold0 = n_d;
      if (p1_v) hold1 = p1_d;
      #1;
      chk("ready", {31'b0, ready0}, 32'd1);
      chk("p0_valid", {31'b0, qv0}, {31'b0, n_v});
      chk("p0_q", q0, hold0);
      chk("p1_valid", {31'b0, qv1}, {31'b0, p1_v});
      chk("p1_q", q1, hold1);
      if (logging && qv0) rd_log.push_back(q0);
   endtask

`ifdef RAM_SP_INIT_CLEAR_EN
   task automatic wait_ready(input string name, input int exp_cycles);
      int   cnt;
      logic saw;
      cnt = 0;
      saw = 1'b0;
      cen = 1'b0; rdwen = 1'b1; a = 6'h3F;
      while (!ready0 && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
         if (qv0 || qv1) saw = 1'b1;
      end
      cen = 1'b1;
      chk(name, cnt, exp_cycles);
      chk("clear_no_valid", {31'b0, saw}, 32'd0);
      chk("p1_ready_after_clear", {31'b0, ready1}, 32'd1);
   endtask
`endif

   initial begin
      logic [31:0] exp_list [$];
      logic        saw;
      rst = 1'b1; cen = 1'b1; rdwen = 1'b1; a = '0; d = '0; wmask = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q0", q0, 32'd0);
      chk("rst_qv0", {31'b0, qv0}, 32'd0);
      chk("rst_q1", q1, 32'd0);
      chk("rst_qv1", {31'b0, qv1}, 32'd0);
`ifdef RAM_SP_INIT_CLEAR_EN
      chk("rst_ready", {31'b0, ready0}, 32'd0);
      for (int i = 0; i < 64; i++) mem_m[i] = '0;
      rst = 1'b0;
      wait_ready("clear_len", 16);
      step(1'b0, 1'b1, 6'h3F, 32'd0, 4'hF);
      chk("read_3f_q", q0, 32'd0);
      chk("read_3f_valid", {31'b0, qv0}, 32'd1);
      step(1'b1, 1'b1, 6'h00, 32'd0, 4'h0);
      // Reset again, then interrupt the clear after seven rows.
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      cen = 1'b0; rdwen = 1'b1; a = 6'h3F;
      saw = 1'b0;
      repeat (7) begin
         @(posedge clk);
         #1;
         if (qv0 || qv1) saw = 1'b1;
      end
      chk("mid_clear_ready", {31'b0, ready0}, 32'd0);
      chk("mid_clear_no_valid", {31'b0, saw}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_in_rst", {31'b0, ready0}, 32'd0);
      rst = 1'b0;
      model_reset();
      wait_ready("reclear_len", 16);
`else
      chk("rst_ready", {31'b0, ready0}, 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 6'(i), $urandom, 4'hF);
`endif

      vecs[0]  = '{1'b0, 1'b0, 6'h05, 32'hDEADBEEF, 4'hF, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 1'b0, 6'h05, 32'h11223344, 4'h5, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
      vecs[4]  = '{1'b0, 1'b0, 6'h04, 32'hA0A0A0A0, 4'hF, 32'h0};
      vecs[5]  = '{1'b0, 1'b0, 6'h06, 32'h60606060, 4'hF, 32'h0};
      vecs[6]  = '{1'b0, 1'b0, 6'h07, 32'h70707070, 4'hF, 32'h0};
      vecs[7]  = '{1'b0, 1'b1, 6'h04, 32'h0,        4'h0, 32'hA0A0A0A0};
      vecs[8]  = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
      vecs[9]  = '{1'b0, 1'b1, 6'h06, 32'h0,        4'h0, 32'h60606060};
      vecs[10] = '{1'b0, 1'b1, 6'h07, 32'h0,        4'h0, 32'h70707070};
      vecs[11] = '{1'b1, 1'b0, 6'h05, 32'hFFFFFFFF, 4'hF, 32'h0};
      vecs[12] = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
      vecs[13] = '{1'b0, 1'b0, 6'h05, 32'h00000000, 4'h0, 32'h0};
      vecs[14] = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hDE22BE44};
      vecs[15] = '{1'b0, 1'b0, 6'h05, 32'hCAFEF00D, 4'hF, 32'h0};
      vecs[16] = '{1'b0, 1'b1, 6'h05, 32'h0,        4'h0, 32'hCAFEF00D};

      rd_log.delete();
      logging = 1'b1;
      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].r, vecs[i].ad, vecs[i].dd, vecs[i].wm);
         if (!vecs[i].c && vecs[i].r) exp_list.push_back(vecs[i].exp_rd);
      end
      repeat (2) step(1'b1, 1'b1, 6'h00, 32'd0, 4'h0);
      logging = 1'b0;
      chk("table_read_count", rd_log.size(), exp_list.size());
      for (int i = 0; i < exp_list.size(); i++) begin
         if (i < rd_log.size()) chk($sformatf("table_read_%0d", i), rd_log[i], exp_list[i]);
      end

      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
      end
      repeat (2) step(1'b1, 1'b1, 6'h00, 32'd0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_sp_banked.md
RAM_SP_BANKED -- requirements
Module: ram_sp_banked

Interface
REQ-001 SHALL have parameter AddrWidth, default 12, meaning total word address width (depth 2**AddrWidth).
REQ-002 SHALL have parameter DataWidth, default 32, meaning word width; multiple of 8.
REQ-003 SHALL have parameter NumBanks, default 4, meaning power-of-2 bank count, 1..2**AddrWidth.
REQ-004 SHALL have parameter Pipelined, default 0, meaning 1 adds an output register stage.
REQ-005 SHALL have port clk, input, 1, meaning the single clock (all logic on posedge).
REQ-006 SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-007 SHALL have port cen, input, 1, meaning access enable, active-low.
REQ-008 SHALL have port rdwen, input, 1, meaning 1 = read, 0 = write.
REQ-009 SHALL have port a, input, AddrWidth, meaning word address.
REQ-010 SHALL have port d, input, DataWidth, meaning write data.
REQ-011 SHALL have port wmask, input, DataWidth/8, meaning per-byte write enable, active-high.
REQ-012 SHALL have port q, output, DataWidth, meaning read data.
REQ-013 SHALL have port q_valid, output, 1, meaning q carries fresh read data this cycle.
REQ-014 SHALL have port ready, output, 1, meaning accesses are accepted.

Function
REQ-015 SHALL select bank = a[log2(NumBanks)-1:0] and row = remaining upper bits (low-order interleave).
REQ-016 SHALL enable only the addressed bank per access; all other banks remain idle.
REQ-017 SHALL accept an access when cen=0 and ready=1; when ready=0, cen=0 is ignored, with no write, no read and no q_valid.
REQ-018 SHALL, on an accepted write, update only bytes with wmask[i]=1; wmask all-zero leaves memory unchanged.
REQ-019 SHALL, on an accepted read, drive q with the data and pulse q_valid for one cycle, 1 cycle later (Pipelined=0) or 2 cycles later (Pipelined=1).
REQ-020 SHALL hold q at the last read value when no read completes; q_valid=0 on those cycles.
REQ-021 SHALL return the newly written data for a read in the cycle after a write to the same address.
REQ-022 SHALL sustain one access per cycle; back-to-back reads produce back-to-back q_valid pulses, in order.

Reset
REQ-023 SHALL, while rst=1, force q=0, q_valid=0 and the pipeline stage to 0; ready=0 if RAM_SP_INIT_CLEAR_EN is defined, else ready=1.
REQ-024 SHALL leave memory contents unchanged by rst itself, except via the clear sequence.

Configuration
REQ-025 SHALL, with RAM_SP_INIT_CLEAR_EN defined, run an FSM CLEAR->READY after rst deasserts: CLEAR writes zero to one row in all banks per cycle, from row 0 upward; ready=1 only in READY.
REQ-026 SHALL complete CLEAR in exactly 2**AddrWidth/NumBanks cycles, and restart from row 0 if rst asserts mid-clear.
REQ-027 SHALL, without RAM_SP_INIT_CLEAR_EN, omit the FSM and row counter; ready is constant 1 outside reset and contents are undefined until written.

Structure
REQ-028 SHALL place the FSM state encoding (CLEAR, READY) and the bank-index-width helper constant in shared package ram_pkg.
REQ-029 SHALL instantiate NumBanks copies of sub-module ram_sp_bank, a one-bank byte-masked single-port array with a registered read.

Verification (AddrWidth=6, DataWidth=32, NumBanks=4)
REQ-030 SHALL check, with CLEAR_EN: rst pulse -> ready=0 for 16 cycles then 1; read 0x3F -> q=0x00000000, q_valid after 1 cycle.
REQ-031 SHALL check: write 0xDEADBEEF@0x05, wmask=4'hF; read 0x05 -> q=0xDEADBEEF at +1 cycle (Pipelined=0) and +2 cycles (Pipelined=1).
REQ-032 SHALL check: write 0x11223344@0x05, wmask=4'b0101, over 0xDEADBEEF -> read returns 0xDE22BE44.
REQ-033 SHALL check: reads 0x04..0x07 on consecutive cycles -> 4 consecutive q_valid pulses with per-address data, in order.
REQ-034 SHALL check: rst asserted at clear cycle 7 -> ready stays 0 and 16 further cycles elapse before ready=1; cen=0 during clear -> no q_valid.
REQ-035 SHALL check: cen=1, rdwen=0, d=0xFFFFFFFF@0x05 -> location unchanged and q holds its prior value.
